// File: rtl/alu_bist_driver.sv
// alu_bist_driver: BIST initiator driving LFSR vectors into the ALU and checking AluOut/Zero against a golden model.
// Latency: one vector per cycle, each compared one cycle after drive; done pulses the cycle after the last compare.
// Backpressure: none; start is edge-detected and only honoured in IDLE. `ALU_BIST_CORNER_EN adds 24 directed corner vectors first.
module alu_bist_driver #(
  parameter int unsigned N_VECTORS = 256,
  parameter logic [31:0] SEED      = 32'hACE12345,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_fail,
  output logic [3:0]       AluCon,
  output logic [31:0]      A,
  output logic [31:0]      B,
  input  logic [31:0]      AluOut,
  input  logic             Zero
);

  localparam logic [31:0]      TAPS     = 32'h80200003;
  localparam logic [31:0]      SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
`ifdef ALU_BIST_CORNER_EN
  localparam int unsigned N_DIR = 24;
  // One extra index bit so N_VECTORS+24 vectors always fit.
  localparam int unsigned IDX_W = 17;
`else
  localparam int unsigned N_DIR = 0;
  localparam int unsigned IDX_W = 16;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VECTORS + N_DIR - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [3:0] op_code(input logic [2:0] op);
    case (op)
      3'd0:    op_code = 4'b0000;  // AND
      3'd1:    op_code = 4'b0001;  // OR
      3'd2:    op_code = 4'b0010;  // ADD
      3'd3:    op_code = 4'b0110;  // SUB
      3'd4:    op_code = 4'b0111;  // SLT
      default: op_code = 4'b1100;  // NOR
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    lfsr_step = (l >> 1) ^ (l[0] ? TAPS : 32'd0);
  endfunction

  function automatic logic [31:0] mix_b(input logic [31:0] l);
    mix_b = {l[15:0], l[31:16]} ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] golden(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: golden = a & b;
      4'b0001: golden = a | b;
      4'b0010: golden = a + b;
      4'b0110: golden = a - b;
      4'b0111: golden = {31'd0, ($signed(a) < $signed(b))};
      4'b1100: golden = ~(a | b);
      default: golden = 32'd0;
    endcase
  endfunction

`ifdef ALU_BIST_CORNER_EN
  function automatic logic [31:0] corner_a(input logic [1:0] p);
    case (p)
      2'd0:    corner_a = 32'h00000000;
      2'd1:    corner_a = 32'hFFFFFFFF;
      2'd2:    corner_a = 32'h80000000;
      default: corner_a = 32'h7FFFFFFF;
    endcase
  endfunction

  function automatic logic [31:0] corner_b(input logic [1:0] p);
    case (p)
      2'd0:    corner_b = 32'h00000000;
      2'd1:    corner_b = 32'h00000001;
      2'd2:    corner_b = 32'h7FFFFFFF;
      default: corner_b = 32'h80000000;
    endcase
  endfunction

  logic       dir_q, dir_d;
  logic [1:0] pair_q, pair_d;
`endif

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       con_q, con_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      ff_q, ff_d;
  logic             pass_q, pass_d;
  logic             start_q;

  logic             start_rise;
  logic [31:0]      exp_res;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;
  logic [2:0]       op_nxt;
  logic [31:0]      lfsr_nxt;

  assign start_rise = start & ~start_q;
  assign op_nxt     = (op_q == 3'd5) ? 3'd0 : op_q + 3'd1;
  assign lfsr_nxt   = lfsr_step(lfsr_q);

  // Golden compare of the ALU's response to the currently registered vector.
  always_comb begin
    exp_res  = golden(con_q, a_q, b_q);
    mismatch = (AluOut != exp_res) || (Zero != (exp_res == 32'd0));
    err_nxt  = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_nxt = err_q + ERR_W'(1);
    end
  end

  // Next-state and vector generation for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    con_d   = con_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
`ifdef ALU_BIST_CORNER_EN
    dir_d   = dir_q;
    pair_d  = pair_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          lfsr_d  = SEED_EFF;
          idx_d   = '0;
          op_d    = 3'd0;
          con_d   = op_code(3'd0);
          err_d   = '0;
          ff_d    = 16'hFFFF;
          pass_d  = 1'b0;
          state_d = S_RUN;
`ifdef ALU_BIST_CORNER_EN
          dir_d   = 1'b1;
          pair_d  = 2'd0;
          a_d     = corner_a(2'd0);
          b_d     = corner_b(2'd0);
`else
          a_d     = SEED_EFF;
          b_d     = mix_b(SEED_EFF);
`endif
        end
      end
      S_RUN: begin
        err_d = err_nxt;
        if (mismatch && (ff_q == 16'hFFFF)) begin
          ff_d = idx_q[15:0];
        end
        if (idx_q == LAST_IDX) begin
          pass_d  = (err_nxt == '0);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
`ifdef ALU_BIST_CORNER_EN
          if (dir_q) begin
            if (pair_q == 2'd3) begin
              pair_d = 2'd0;
              if (op_q == 3'd5) begin
                // Directed phase over: first random vector uses the unadvanced seed.
                dir_d = 1'b0;
                op_d  = 3'd0;
                a_d   = lfsr_q;
                b_d   = mix_b(lfsr_q);
              end else begin
                op_d = op_q + 3'd1;
                a_d  = corner_a(2'd0);
                b_d  = corner_b(2'd0);
              end
            end else begin
              pair_d = pair_q + 2'd1;
              a_d    = corner_a(pair_q + 2'd1);
              b_d    = corner_b(pair_q + 2'd1);
            end
          end else begin
            op_d   = op_nxt;
            lfsr_d = lfsr_nxt;
            a_d    = lfsr_nxt;
            b_d    = mix_b(lfsr_nxt);
          end
`else
          op_d   = op_nxt;
          lfsr_d = lfsr_nxt;
          a_d    = lfsr_nxt;
          b_d    = mix_b(lfsr_nxt);
`endif
          con_d = op_code(op_d);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and vector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      con_q   <= 4'b0000;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      ff_q    <= 16'hFFFF;
      pass_q  <= 1'b0;
      start_q <= 1'b0;
`ifdef ALU_BIST_CORNER_EN
      dir_q   <= 1'b0;
      pair_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      con_q   <= con_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      start_q <= start;
`ifdef ALU_BIST_CORNER_EN
      dir_q   <= dir_d;
      pair_q  <= pair_d;
`endif
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign AluCon     = con_q;
  assign A          = a_q;
  assign B          = b_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: behavioural ALU with selectable faults plus a vector-list reference model.
// Two instances: N_VECTORS=12 with default seed, and N_VECTORS=1 with seed 0.
module tb_alu_bist_driver;

  localparam int N0 = 12;
  localparam logic [31:0] SEED0 = 32'hACE12345;
`ifdef ALU_BIST_CORNER_EN
  localparam int NDIR = 24;
`else
  localparam int NDIR = 0;
`endif
  localparam int L0   = N0 + NDIR;
  localparam int L1   = 1 + NDIR;
  localparam int MAXL = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, err1, ff0, ff1;
  logic [3:0]  con0, con1;
  logic [31:0] a0, b0, a1, b1, out0, out1;
  logic        z0, z1;
  int          fault_mode;

  int total = 0;
  int bad   = 0;

  logic [3:0]  m_con [MAXL];
  logic [31:0] m_a   [MAXL];
  logic [31:0] m_b   [MAXL];

  always #5 clk = ~clk;

  alu_bist_driver #(.N_VECTORS(N0), .SEED(SEED0), .ERR_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0), .AluCon(con0), .A(a0), .B(b0), .AluOut(out0), .Zero(z0)
  );

  alu_bist_driver #(.N_VECTORS(1), .SEED(32'h0), .ERR_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .AluCon(con1), .A(a1), .B(b1), .AluOut(out1), .Zero(z1)
  );

  // Behavioural ALU; fault 1 flips ADD bit 0, fault 2 holds Zero low.
  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input int fault);
    logic [31:0] r;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = 32'd0;
    endcase
    if (fault == 1 && c == 4'b0010) r = r ^ 32'd1;
    return {(fault == 2) ? 1'b0 : (r == 32'd0), r};
  endfunction

  always_comb {z0, out0} = alu_ref(con0, a0, b0, fault_mode);
  always_comb {z1, out1} = alu_ref(con1, a1, b1, 0);

  // Expected vector list of a whole run, built straight from the operand/op rules.
  task automatic build_model(input logic [31:0] seed, input int n);
    logic [3:0]  codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [31:0] pa [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] pb [4] = '{32'h0, 32'h00000001, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] l;
    int k;
    k = 0;
    l = (seed == 32'd0) ? 32'd1 : seed;
    if (NDIR > 0) begin
      for (int op = 0; op < 6; op++) begin
        for (int p = 0; p < 4; p++) begin
          m_con[k] = codes[op]; m_a[k] = pa[p]; m_b[k] = pb[p]; k++;
        end
      end
    end
    for (int j = 0; j < n; j++) begin
      m_con[k] = codes[j % 6];
      m_a[k]   = l;
      m_b[k]   = {l[15:0], l[31:16]} ^ 32'h5A5A5A5A;
      l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
      k++;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete run on instance 0; optionally leaves start held high.
  task automatic do_run(input int fault, input bit hold);
    int ne, ff;
    fault_mode = fault;
    build_model(SEED0, N0);
    tick($urandom_range(0, 3));
    start0 = 1'b1;
    tick(1);
    if (!hold) start0 = 1'b0;
    ne = 0;
    ff = 16'hFFFF;
    for (int i = 0; i < L0; i++) begin
      check("busy_run", busy0, 1);
      check("done_run", done0, 0);
      check("alucon", con0, m_con[i]);
      check("opa", a0, m_a[i]);
      check("opb", b0, m_b[i]);
      check("err_run", err0, ne);
      check("ff_run", ff0, ff);
      if (i == 0) check("pass_clr", pass0, 0);
      if (alu_ref(m_con[i], m_a[i], m_b[i], fault) !== alu_ref(m_con[i], m_a[i], m_b[i], 0)) begin
        if (ff == 16'hFFFF) ff = i;
        ne++;
      end
      tick(1);
    end
    check("done_pulse", done0, 1);
    check("busy_done", busy0, 0);
    check("pass_end", pass0, (ne == 0) ? 1 : 0);
    check("err_end", err0, ne);
    check("ff_end", ff0, ff);
    check("hold_con", con0, m_con[L0-1]);
    check("hold_a", a0, m_a[L0-1]);
    check("hold_b", b0, m_b[L0-1]);
    tick(1);
    check("done_low", done0, 0);
    check("busy_idle", busy0, 0);
    check("pass_held", pass0, (ne == 0) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; fault_mode = 0;
    tick(3);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_ff", ff0, 16'hFFFF);
    check("rst_con", con0, 0);
    check("rst_a", a0, 0);
    check("rst_b", b0, 0);
    check("rst_busy1", busy1, 0);
    check("rst_ff1", ff1, 16'hFFFF);
    reset = 1'b0;
    tick(1);

    do_run(0, 1'b0);
    do_run(1, 1'b0);
    do_run(2, 1'b0);

    // Abort in the 4th RUN cycle; no done, reset values restored.
    fault_mode = 1;
    build_model(SEED0, N0);
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(3);
    check("abort_busy_pre", busy0, 1);
    check("abort_a_pre", a0, m_a[3]);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_err", err0, 0);
    check("abort_ff", ff0, 16'hFFFF);
    check("abort_con", con0, 0);
    check("abort_a", a0, 0);
    check("abort_b", b0, 0);
    tick(1);
    check("abort_no_done", done0, 0);
    do_run(0, 1'b0);

    // start held high for 20 cycles must yield a single run.
    do_run(0, 1'b1);
    for (int i = 0; i < 20 - (L0 + 2); i++) begin
      check("hold_busy", busy0, 0);
      check("hold_done", done0, 0);
      tick(1);
    end
    start0 = 1'b0;
    tick(2);
    do_run(0, 1'b0);

    // SEED=0, N_VECTORS=1 instance.
    build_model(32'h0, 1);
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    for (int i = 0; i < L1; i++) begin
      check("n1_busy", busy1, 1);
      check("n1_con", con1, m_con[i]);
      check("n1_a", a1, m_a[i]);
      check("n1_b", b1, m_b[i]);
      tick(1);
    end
    check("n1_done", done1, 1);
    check("n1_busy_end", busy1, 0);
    check("n1_pass", pass1, 1);
    check("n1_err", err1, 0);
    check("n1_ff", ff1, 16'hFFFF);
    tick(1);
    check("n1_done_low", done1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
